// File: rtl/parallel2serial_stream.sv
// parallel2serial_stream: WIDTH-bit parallel to serial converter with
// valid/ready handshakes on both sides and a one-word holding register so
// consecutive frames stream with no idle cycle between them.
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are high. The producer holds valid (and data) until it sees
// ready. Ready never depends combinationally on valid. All outputs are
// decoded from registers only.
//
// Optional feature macro: P2S_PARITY_EN. When it is defined, each frame
// gets one even-parity bit (XOR of the word) appended after the data bits.
// The parity bit carries last_o. When it is undefined, no parity logic is
// built.
module parallel2serial_stream #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  output logic             serial_o,
  output logic             valid_o,
  input  logic             serial_ready_i,
  output logic             last_o,
  output logic             empty_o,
  output logic             dbg_state
);

`ifdef P2S_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [FRAME-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold;
  logic             hold_full;

  logic load_fire;
  logic bit_fire;
  logic end_frame;

  // Arrange a word as a frame so the first bit to leave sits at the output end
  // of the shifter; the parity bit, when present, sits at the far end.
  function automatic logic [FRAME-1:0] make_frame(input logic [WIDTH-1:0] w);
`ifdef P2S_PARITY_EN
    if (MSB_FIRST != 0) make_frame = {w, ^w};
    else                make_frame = {^w, w};
`else
    make_frame = w;
`endif
  endfunction

  // Advance the shifter one position toward its output end.
  function automatic logic [FRAME-1:0] shift_once(input logic [FRAME-1:0] s);
    if (MSB_FIRST != 0) shift_once = {s[FRAME-2:0], 1'b0};
    else                shift_once = {1'b0, s[FRAME-1:1]};
  endfunction

  assign load_ready_o = !hold_full;
  assign valid_o      = (state == SHIFT);
  assign serial_o     = valid_o & ((MSB_FIRST != 0) ? shreg[FRAME-1] : shreg[0]);
  assign last_o       = valid_o & (cnt == CNT_ONE);
  assign empty_o      = !valid_o & !hold_full;
  assign dbg_state    = state;

  assign load_fire = load_valid_i & !hold_full;
  assign bit_fire  = valid_o & serial_ready_i;
  assign end_frame = bit_fire & (cnt == CNT_ONE);

  // Shifter FSM plus holding register; words bypass hold whenever the
  // shifter is free on the edge they arrive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_fire) begin
            shreg <= make_frame(parallel_i);
            cnt   <= CNT_FULL;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_fire) begin
            if (cnt == CNT_ONE) begin
              if (hold_full) begin
                shreg     <= make_frame(hold);
                cnt       <= CNT_FULL;
                hold_full <= 1'b0;
              end else if (load_fire) begin
                shreg <= make_frame(parallel_i);
                cnt   <= CNT_FULL;
              end else begin
                shreg <= '0;
                cnt   <= '0;
                state <= IDLE;
              end
            end else begin
              shreg <= shift_once(shreg);
              cnt   <= cnt - CNT_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A word accepted while the shifter is busy (and not freed by a bypass
      // on this edge) waits in hold.
      if (load_fire && (state == SHIFT) && !(end_frame && !hold_full)) begin
        hold      <= parallel_i;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parallel2serial_stream.sv
// Directed bench for parallel2serial_stream at WIDTH=4. A table of per-cycle
// records drives the MSB-first instance; a second LSB-first instance is
// exercised by a short hand-written sequence.
module tb_parallel2serial_stream;

  localparam int W = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // MSB-first instance signals
  logic [W-1:0] parallel_i = '0;
  logic         load_valid_i = 1'b0;
  logic         serial_ready_i = 1'b1;
  logic         load_ready_o, serial_o, valid_o, last_o, empty_o, dbg_state;

  // LSB-first instance signals
  logic [W-1:0] l_parallel = '0;
  logic         l_load_valid = 1'b0;
  logic         l_serial_ready = 1'b1;
  logic         l_load_ready, l_serial, l_valid, l_last, l_empty, l_dbg_state;

  parallel2serial_stream #(.WIDTH(W), .MSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .parallel_i(parallel_i),
    .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .serial_o(serial_o), .valid_o(valid_o), .serial_ready_i(serial_ready_i),
    .last_o(last_o), .empty_o(empty_o), .dbg_state(dbg_state)
  );

  parallel2serial_stream #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .parallel_i(l_parallel),
    .load_valid_i(l_load_valid), .load_ready_o(l_load_ready),
    .serial_o(l_serial), .valid_o(l_valid), .serial_ready_i(l_serial_ready),
    .last_o(l_last), .empty_o(l_empty), .dbg_state(l_dbg_state)
  );

  // One record per clock cycle: inputs for that cycle and the outputs
  // expected during it (outputs are registered, so they do not depend on
  // the inputs of the same cycle).
  typedef struct {
    logic         rst;
    logic         lv;
    logic [W-1:0] p;
    logic         rdy;
    logic         e_valid;
    logic         e_serial;
    logic         e_last;
    logic         e_ready;
    logic         e_empty;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic rst, input logic lv, input logic [W-1:0] p,
                     input logic rdy, input logic ev, input logic es,
                     input logic el, input logic er, input logic ee);
    vec_t v;
    v.rst = rst; v.lv = lv; v.p = p; v.rdy = rdy;
    v.e_valid = ev; v.e_serial = es; v.e_last = el; v.e_ready = er; v.e_empty = ee;
    vecs.push_back(v);
  endtask

  // Scoreboard comparison
  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  // Expected LSB-first bit stream for word 4'b1100
`ifdef P2S_PARITY_EN
  logic exp_q[$] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
  logic exp_q[$] = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif

  initial begin
`ifdef P2S_PARITY_EN
    // parity: 1011 -> 1,0,1,1,1
    add(0,1,4'b1011,1, 0,0,0,1,1);
    add(0,0,4'b0000,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,0,0,1,0);
    add(0,0,4'b0000,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,1,1,1,0);
    // parity: 1001 -> 1,0,0,1,0
    add(0,1,4'b1001,1, 0,0,0,1,1);
    add(0,0,4'b0000,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,0,0,1,0);
    add(0,0,4'b0000,1, 1,0,0,1,0);
    add(0,0,4'b0000,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,0,1,1,0);
    // reset mid-frame with hold full, then 1000 -> 1,0,0,0,1
    add(0,1,4'b1111,1, 0,0,0,1,1);
    add(0,1,4'b0101,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,1,0,0,0);
    add(1,0,4'b0000,1, 1,1,0,0,0);
    add(0,1,4'b1000,1, 0,0,0,1,1);
    add(0,0,4'b0000,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,0,0,1,0);
    add(0,0,4'b0000,1, 1,0,0,1,0);
    add(0,0,4'b0000,1, 1,0,0,1,0);
    add(0,0,4'b0000,1, 1,1,1,1,0);
    add(0,0,4'b0000,1, 0,0,0,1,1);
`else
    // basic order: 1010 -> 1,0,1,0
    add(0,1,4'b1010,1, 0,0,0,1,1);
    add(0,0,4'b0000,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,0,0,1,0);
    add(0,0,4'b0000,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,0,1,1,0);
    // back-to-back: 1100 then 0011; a load attempt while hold is full is ignored
    add(0,1,4'b1100,1, 0,0,0,1,1);
    add(0,1,4'b0011,1, 1,1,0,1,0);
    add(0,1,4'b1111,1, 1,1,0,0,0);
    add(0,0,4'b0000,1, 1,0,0,0,0);
    add(0,0,4'b0000,1, 1,0,1,0,0);
    add(0,0,4'b0000,1, 1,0,0,1,0);
    add(0,0,4'b0000,1, 1,0,0,1,0);
    add(0,0,4'b0000,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,1,1,1,0);
    // stall: 0110 with ready low for 3 cycles on the 2nd bit
    add(0,1,4'b0110,1, 0,0,0,1,1);
    add(0,0,4'b0000,1, 1,0,0,1,0);
    add(0,0,4'b0000,0, 1,1,0,1,0);
    add(0,0,4'b0000,0, 1,1,0,1,0);
    add(0,0,4'b0000,0, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,0,1,1,0);
    // reset mid-frame with hold full, then 1000 -> 1,0,0,0
    add(0,1,4'b1111,1, 0,0,0,1,1);
    add(0,1,4'b0101,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,1,0,0,0);
    add(1,0,4'b0000,1, 1,1,0,0,0);
    add(0,1,4'b1000,1, 0,0,0,1,1);
    add(0,0,4'b0000,1, 1,1,0,1,0);
    add(0,0,4'b0000,1, 1,0,0,1,0);
    add(0,0,4'b0000,1, 1,0,0,1,0);
    add(0,0,4'b0000,1, 1,0,1,1,0);
    add(0,0,4'b0000,1, 0,0,0,1,1);
`endif

    // Reset held for two edges; the first table row checks reset values.
    repeat (2) @(posedge clk);

    // Table-driven section (MSB-first instance)
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset          = vecs[i].rst;
      load_valid_i   = vecs[i].lv;
      parallel_i     = vecs[i].p;
      serial_ready_i = vecs[i].rdy;
      check("valid_o",      i, valid_o,      vecs[i].e_valid);
      check("serial_o",     i, serial_o,     vecs[i].e_serial);
      check("last_o",       i, last_o,       vecs[i].e_last);
      check("load_ready_o", i, load_ready_o, vecs[i].e_ready);
      check("empty_o",      i, empty_o,      vecs[i].e_empty);
    end
    @(negedge clk);
    load_valid_i = 1'b0;

    // Hand-written sequence: LSB-first 1100
    check("lsb_empty_idle", 0, l_empty, 1'b1);
    l_load_valid = 1'b1;
    l_parallel   = 4'b1100;
    @(negedge clk);
    l_load_valid = 1'b0;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      logic b;
      b = exp_q.pop_front();
      check("lsb_valid",  k, l_valid,  1'b1);
      check("lsb_serial", k, l_serial, b);
      check("lsb_last",   k, l_last,   exp_q.size() == 0);
      @(negedge clk);
    end
    check("lsb_valid_end", 0, l_valid, 1'b0);
    check("lsb_empty_end", 0, l_empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
